// File: rtl/pmod_dac_spi.sv
// SPI write engine for daisy-chained serial-input DACs on a Pmod header.
// Owns the complete nCS / SCLK / DIN / nLDAC sequence for one transfer of
// NUM_CH*DATA_W bits, MSB of the farthest DAC first, with optional LDAC pulse.
module pmod_dac_spi #(
  parameter int DATA_W  = 16,
  parameter int NUM_CH  = 1,
  parameter int CLK_DIV = 2,
  parameter int LDAC_W  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] data,
  input  logic                     ldac_en,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     sclk,
  output logic                     din,
  output logic                     nCS,
  output logic                     nLDAC
);

  localparam int N      = NUM_CH * DATA_W;
  localparam int BC_W   = $clog2(N + 1);
  localparam int PH_MAX = (CLK_DIV > LDAC_W) ? CLK_DIV : LDAC_W;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] PH_DIV_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_LDAC_LAST = PH_W'(LDAC_W - 1);
  localparam logic [BC_W-1:0] BC_LAST      = BC_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP, LDAC, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic [N-1:0]    sr_q, sr_d;
  logic            ldac_en_q, ldac_en_d;
  logic            sclk_q, sclk_d;
  logic            din_q, din_d;
  logic            ncs_q, ncs_d;
  logic            nldac_q, nldac_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ph_last;

  // Next-state, datapath and registered-output decode.
  // Outputs are decoded from state_d so that every pin comes straight off a flop
  // and changes in the same edge as the state it belongs to.
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    bc_d      = bc_q;
    sr_d      = sr_q;
    ldac_en_d = ldac_en_q;
    din_d     = din_q;

    ph_last = (state_q == LDAC) ? (ph_q == PH_LDAC_LAST) : (ph_q == PH_DIV_LAST);

    if (state_q == IDLE || state_q == DONE) begin
      ph_d = '0;
    end else begin
      ph_d = ph_last ? '0 : ph_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d      = data;
          ldac_en_d = ldac_en;
          din_d     = data[N-1];
          bc_d      = '0;
          state_d   = SETUP;
        end
      end
      SETUP:    if (ph_last) state_d = SHIFT_LO;
      SHIFT_LO: if (ph_last) state_d = SHIFT_HI;
      SHIFT_HI: begin
        if (ph_last) begin
          bc_d = bc_q + 1'b1;
          if (bc_q == BC_LAST) begin
            state_d = HOLD;
          end else begin
            // Next bit is presented on entry to SHIFT_LO, while sclk falls.
            sr_d    = sr_q << 1;
            din_d   = sr_d[N-1];
            state_d = SHIFT_LO;
          end
        end
      end
      HOLD: if (ph_last) state_d = GAP;
      GAP:  if (ph_last) state_d = ldac_en_q ? LDAC : DONE;
      LDAC: if (ph_last) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        din_d   = 1'b0;
        bc_d    = '0;
      end
      default: state_d = IDLE;
    endcase

    ncs_d   = !(state_d inside {SETUP, SHIFT_LO, SHIFT_HI, HOLD});
    sclk_d  = (state_d != SHIFT_LO);
    nldac_d = (state_d != LDAC);
    busy_d  = !(state_d inside {IDLE, DONE});
    done_d  = (state_d == DONE);
  end

  // State, counters, shift register and output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ph_q      <= '0;
      bc_q      <= '0;
      sr_q      <= '0;
      ldac_en_q <= 1'b0;
      sclk_q    <= 1'b1;
      din_q     <= 1'b0;
      ncs_q     <= 1'b1;
      nldac_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      bc_q      <= bc_d;
      sr_q      <= sr_d;
      ldac_en_q <= ldac_en_d;
      sclk_q    <= sclk_d;
      din_q     <= din_d;
      ncs_q     <= ncs_d;
      nldac_q   <= nldac_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sclk  = sclk_q;
  assign din   = din_q;
  assign nCS   = ncs_q;
  assign nLDAC = nldac_q;

endmodule
